// File: rtl/dds_dual_nco.sv
`default_nettype none
// ============================================================================
//  Module   : dds_dual_nco
//  Purpose  : Dual-channel NCO. Two phase accumulators (S = carrier,
//             C = modulating tone) share one cosine table. Outputs are an
//             offset-binary carrier and a signed tone. They are
//             cycle-aligned through a three-stage pipeline.
//             Tuning words are double-buffered: a write lands in a shadow
//             register and becomes active at the channel's next phase wrap.
//             If the channel is parked at FTW 0, the word becomes active
//             on the next enabled cycle. A sync also makes it active.
//  Ports    : clk          rising-edge clock
//             rst          asynchronous active-high reset
//             en_i         advance both accumulators
//             sync_i       clear both phases, force pending words active
//             cfg_we_i     tuning-word write strobe
//             cfg_sel_i    0 = carrier (S), 1 = modulating (C)
//             cfg_ftw_i    tuning-word data
//             cfg_ack_o    per-channel pulse when a written word goes live
//             cos_s_o      carrier, unsigned offset binary (1..255)
//             cos_c_o      modulating tone, two's complement (-127..127)
//             out_valid_o  outputs belong to an enabled accumulator step
//  Revision : 1.0  initial release
// ============================================================================
module dds_dual_nco #(
  parameter int                 PHASE_W    = 32,
  parameter logic [PHASE_W-1:0] FTW_S_INIT = 'h0100_0000,
  parameter logic [PHASE_W-1:0] FTW_C_INIT = 'h0010_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic               sync_i,
  input  logic               cfg_we_i,
  input  logic               cfg_sel_i,
  input  logic [PHASE_W-1:0] cfg_ftw_i,
  output logic [1:0]         cfg_ack_o,
  output logic [7:0]         cos_s_o,
  output logic [7:0]         cos_c_o,
  output logic               out_valid_o
);

  // pi * 2^60, used to build the quarter-wave table at elaboration time.
  localparam logic [127:0] C_PI_Q60 = 128'h3243F6A8885A308D;

  // round(127 * cos(2*pi*idx/1024)) for idx in 0..256.
  // The value is evaluated with a Q60 Taylor series, which is far more
  // precise than the 8-bit result needs. In the first quadrant the cosine
  // is non-negative, so adding one half and truncating rounds ties away
  // from zero. The clamp absorbs the truncation residue at idx = 256.
  function automatic logic [6:0] f_qcos(input int idx);
    logic [127:0]        theta;
    logic [127:0]        theta2;
    logic [127:0]        term;
    logic signed [127:0] sum;
    logic signed [127:0] scaled;
    theta  = (C_PI_Q60 * 128'(idx)) >> 9;
    theta2 = (theta * theta) >> 60;
    term   = 128'd1 << 60;
    sum    = $signed(term);
    for (int k = 1; k <= 12; k++) begin
      term = ((term * theta2) >> 60) / 128'((2 * k - 1) * (2 * k));
      if (k[0]) sum = sum - $signed(term);
      else      sum = sum + $signed(term);
    end
    scaled = (sum * 128'sd127 + (128'sd1 <<< 59)) >>> 60;
    if (scaled < 0)   return 7'd0;
    if (scaled > 127) return 7'd127;
    return scaled[6:0];
  endfunction

  // --------------------------------------------------------------------------
  // Per-channel control state (index 0 = S, index 1 = C)
  // --------------------------------------------------------------------------
  logic [1:0][PHASE_W-1:0] acc_q, acc_d;
  logic [1:0][PHASE_W-1:0] ftw_q, ftw_d;
  logic [1:0][PHASE_W-1:0] shd_q, shd_d;
  logic [1:0]              pend_q, pend_d;
  logic [1:0]              cfg_ack_q, cfg_ack_d;

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic [PHASE_W:0] w_sum;
    logic             w_we;
    logic             w_wrap;
    logic             w_apply;

    assign w_sum  = {1'b0, acc_q[ch]} + {1'b0, ftw_q[ch]};
    assign w_we   = cfg_we_i && (cfg_sel_i == 1'(ch));
    assign w_wrap = en_i && w_sum[PHASE_W];

    // A channel parked at FTW 0 never wraps. For that channel, a pending
    // word goes live on the next enabled cycle instead.
    assign w_apply = pend_q[ch] &&
                     (sync_i || w_wrap || (en_i && (ftw_q[ch] == '0)));

    assign acc_d[ch] = sync_i ? '0 : (en_i ? w_sum[PHASE_W-1:0] : acc_q[ch]);

    // The apply always consumes the shadow value held before this edge.
    // A write in the same cycle refills the shadow and stays pending.
    assign ftw_d[ch]     = w_apply ? shd_q[ch] : ftw_q[ch];
    assign shd_d[ch]     = w_we ? cfg_ftw_i : shd_q[ch];
    assign pend_d[ch]    = w_we | (pend_q[ch] & ~w_apply);
    assign cfg_ack_d[ch] = w_apply;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      ftw_q     <= {FTW_C_INIT, FTW_S_INIT};
      shd_q     <= {FTW_C_INIT, FTW_S_INIT};
      pend_q    <= '0;
      cfg_ack_q <= '0;
    end else begin
      acc_q     <= acc_d;
      ftw_q     <= ftw_d;
      shd_q     <= shd_d;
      pend_q    <= pend_d;
      cfg_ack_q <= cfg_ack_d;
    end
  end

  // --------------------------------------------------------------------------
  // Quarter-wave cosine table, 257 entries (0..pi/2 inclusive)
  // --------------------------------------------------------------------------
  logic [6:0] w_rom [0:256];

  for (genvar g = 0; g <= 256; g++) begin : g_rom
    localparam logic [6:0] C_VAL = f_qcos(g);
    assign w_rom[g] = C_VAL;
  end

  // --------------------------------------------------------------------------
  // Three-stage output pipeline: phase index -> table value -> output
  // --------------------------------------------------------------------------
  logic [1:0][9:0] ph_q;
  logic [1:0][7:0] tab_q, tab_d;
  logic [1:0]      ld_q;
  logic [1:0]      vld_q;
  logic [7:0]      cos_s_q;
  logic [7:0]      cos_c_q;
  logic            out_valid_q;

  // Fold the 10-bit phase onto the quarter wave. Quadrants 1 and 3 read
  // the table mirrored. Quadrants 1 and 2 negate the value.
  for (genvar ch = 0; ch < 2; ch++) begin : g_rd
    logic [8:0] w_idx;
    logic [6:0] w_mag;

    assign w_idx = ph_q[ch][8] ? (9'd256 - {1'b0, ph_q[ch][7:0]})
                               : {1'b0, ph_q[ch][7:0]};
    assign w_mag = w_rom[w_idx];
    assign tab_d[ch] = (ph_q[ch][9] ^ ph_q[ch][8]) ? -{1'b0, w_mag}
                                                   : {1'b0, w_mag};
  end

  // After reset, ld_q holds the table and output stages until a real
  // phase has reached them. Without this, the reset value of the phase
  // register would be read out as a genuine sample one cycle early.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_q        <= '0;
      ld_q        <= '0;
      tab_q       <= '0;
      vld_q       <= '0;
      cos_s_q     <= 8'd128;
      cos_c_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ph_q[0] <= acc_q[0][PHASE_W-1 -: 10];
      ph_q[1] <= acc_q[1][PHASE_W-1 -: 10];
      ld_q    <= {ld_q[0], 1'b1};
      if (ld_q[0]) begin
        tab_q <= tab_d;
      end
      if (ld_q[1]) begin
        cos_s_q <= tab_q[0] + 8'd128;
        cos_c_q <= tab_q[1];
      end
      vld_q       <= {vld_q[0], en_i};
      out_valid_q <= vld_q[1];
    end
  end

  assign cfg_ack_o   = cfg_ack_q;
  assign cos_s_o     = cos_s_q;
  assign cos_c_o     = cos_c_q;
  assign out_valid_o = out_valid_q;

endmodule
`default_nettype wire
